// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes, optional signed input, overflow flag and leading-zero blanking.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   acc_q;
    logic [BCD_W-1:0]   acc_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               ovf_q;
    logic               ovf_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   mag;

    // Two's-complement magnitude in BIN_W unsigned bits, so -2^(BIN_W-1) maps to 2^(BIN_W-1).
    always_comb begin
        mag = bin;
        if (SIGNED && bin[BIN_W-1]) begin
            mag = ~bin + BIN_W'(1);
        end
    end

    always_comb begin
        adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        acc_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
        ovf_d = ovf_q | adj[BCD_W-1];
    end

    // Scan from the most significant digit down; the units digit is never blanked.
    always_comb begin
        logic allZero;
        allZero = 1'b1;
        blank   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allZero  = allZero & (acc_q[4*k +: 4] == 4'd0);
            blank[k] = allZero;
        end
        blank[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q    <= mag;
                        neg_q      <= SIGNED && bin[BIN_W-1];
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CNT_W'(BIN_W);
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_d;
                    shift_q <= {shift_q[BIN_W-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = acc_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: three instances (unsigned 5 digits, signed 5 digits,
// unsigned 4 digits) checked every cycle against an arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cur = 0;
    bit          running = 1'b0;
    logic [2:0]  inValid = '0;
    logic [2:0]  outReady = '0;
    logic [2:0]  inReadyV;
    logic [2:0]  outValidV;
    logic [2:0]  negV;
    logic [2:0]  ovfV;
    logic [15:0] binIn [3];
    logic [19:0] bcd0;
    logic [19:0] bcd1;
    logic [15:0] bcd2;
    logic [4:0]  blank0;
    logic [4:0]  blank1;
    logic [3:0]  blank2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) uUns (
        .clk(clk), .reset(rst), .in_valid(inValid[0]), .in_ready(inReadyV[0]),
        .bin(binIn[0]), .out_valid(outValidV[0]), .out_ready(outReady[0]),
        .bcd(bcd0), .neg(negV[0]), .ovf(ovfV[0]), .blank(blank0));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) uSgn (
        .clk(clk), .reset(rst), .in_valid(inValid[1]), .in_ready(inReadyV[1]),
        .bin(binIn[1]), .out_valid(outValidV[1]), .out_ready(outReady[1]),
        .bcd(bcd1), .neg(negV[1]), .ovf(ovfV[1]), .blank(blank1));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(1'b0)) uDig4 (
        .clk(clk), .reset(rst), .in_valid(inValid[2]), .in_ready(inReadyV[2]),
        .bin(binIn[2]), .out_valid(outValidV[2]), .out_ready(outReady[2]),
        .bcd(bcd2), .neg(negV[2]), .ovf(ovfV[2]), .blank(blank2));

    function automatic logic [19:0] getBcd(input int i);
        case (i)
            0:       return bcd0;
            1:       return bcd1;
            default: return {4'h0, bcd2};
        endcase
    endfunction

    function automatic logic [4:0] getBlank(input int i);
        case (i)
            0:       return blank0;
            1:       return blank1;
            default: return {1'b0, blank2};
        endcase
    endfunction

    // Reference result from plain decimal arithmetic on the input value.
    function automatic void computeExp(input int inst, input logic [15:0] v,
                                       output logic [19:0] eb, output logic en,
                                       output logic eo, output logic [4:0] ebl);
        int digits;
        int lim;
        int mag;
        int res;
        int t;
        int nd;
        digits = (inst == 2) ? 4 : 5;
        lim    = (inst == 2) ? 10000 : 100000;
        en     = (inst == 1) && v[15];
        mag    = en ? (65536 - int'(v)) : int'(v);
        eo     = (mag >= lim);
        res    = mag % lim;
        eb     = '0;
        t      = res;
        for (int k = 0; k < digits; k++) begin
            eb[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nd = 1;
        t  = res;
        while (t >= 10) begin
            t  = t / 10;
            nd = nd + 1;
        end
        ebl = '0;
        for (int k = 1; k < digits; k++) begin
            ebl[k] = (k >= nd);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: 0 = waiting for input, 1 = converting (16 clocks), 2 = result held.
    int          mPhase = 0;
    int          mCnt = 0;
    logic [19:0] eBcd = '0;
    logic        eNeg = 1'b0;
    logic        eOvf = 1'b0;
    logic [4:0]  eBlank = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = 0;
        end else begin
            case (mPhase)
                0: if (inValid[cur]) begin
                    computeExp(cur, binIn[cur], eBcd, eNeg, eOvf, eBlank);
                    mPhase = 1;
                    mCnt   = 16;
                end
                1: begin
                    mCnt = mCnt - 1;
                    if (mCnt == 0) mPhase = 2;
                end
                2: if (outReady[cur]) mPhase = 0;
                default: mPhase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (running && !rst) begin
            checkOutput("in_ready", inReadyV[cur], mPhase == 0);
            checkOutput("out_valid", outValidV[cur], mPhase == 2);
            if (mPhase == 2) begin
                checkOutput("bcd", getBcd(cur), eBcd);
                checkOutput("neg", negV[cur], eNeg);
                checkOutput("ovf", ovfV[cur], eOvf);
                checkOutput("blank", getBlank(cur), eBlank);
            end
        end
    end

    task automatic applyStimulus(input int inst, input logic [15:0] v, input int hold,
                                 input bit noise, input bit checkLit,
                                 input logic [19:0] litBcd, input logic litNeg,
                                 input logic litOvf, input logic [4:0] litBlank,
                                 output int lowCnt);
        int lat;
        int n;
        lowCnt = 0;
        lat    = -1;
        cur    = inst;
        n      = 0;
        while (!inReadyV[inst] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReadyV[inst]) checkOutput("in_ready_timeout", 0, 1);
        inValid[inst]  = 1'b1;
        binIn[inst]    = v;
        outReady[inst] = (hold == 0);
        @(negedge clk);
        inValid[inst] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!inReadyV[inst]) lowCnt++;
            if (outValidV[inst]) begin
                lat = k;
                break;
            end
            if (noise) begin
                inValid[inst] = 1'($urandom);
                binIn[inst]   = 16'($urandom);
            end
            @(negedge clk);
        end
        inValid[inst] = 1'b0;
        checkOutput("latency", lat, 16);
        if (checkLit) begin
            checkOutput("lit_bcd", getBcd(inst), litBcd);
            checkOutput("lit_neg", negV[inst], litNeg);
            checkOutput("lit_ovf", ovfV[inst], litOvf);
            checkOutput("lit_blank", getBlank(inst), litBlank);
        end
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                inValid[inst] = 1'($urandom);
                binIn[inst]   = 16'($urandom);
            end
            @(negedge clk);
        end
        inValid[inst]  = 1'b0;
        outReady[inst] = 1'b1;
        if (hold > 0 && checkLit) begin
            checkOutput("held_out_valid", outValidV[inst], 1);
            checkOutput("held_bcd", getBcd(inst), litBcd);
        end
        @(negedge clk);
        for (int k = 0; k < 5 && !inReadyV[inst]; k++) begin
            lowCnt++;
            @(negedge clk);
        end
        outReady[inst] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowCnt;
        int inst;
        int sel;
        logic [15:0] v;
        for (int i = 0; i < 3; i++) binIn[i] = '0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", inReadyV[0], 1);
        checkOutput("reset_out_valid", outValidV[0], 0);
        checkOutput("reset_bcd", bcd0, 0);
        checkOutput("reset_blank5", blank0, 5'b11110);
        checkOutput("reset_blank4", blank2, 4'b1110);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        running = 1'b1;

        $display("[TB] full-scale unsigned");
        applyStimulus(0, 16'hFFFF, 0, 1'b0, 1'b1, 20'h65535, 1'b0, 1'b0, 5'b00000, lowCnt);
        checkOutput("in_ready_low_cycles", lowCnt, 17);

        $display("[TB] zero and blanking");
        applyStimulus(0, 16'd0, 0, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b0, 5'b11110, lowCnt);
        applyStimulus(0, 16'd42, 0, 1'b0, 1'b1, 20'h00042, 1'b0, 1'b0, 5'b11100, lowCnt);

        $display("[TB] signed extremes");
        applyStimulus(1, 16'h8000, 0, 1'b0, 1'b1, 20'h32768, 1'b1, 1'b0, 5'b00000, lowCnt);
        applyStimulus(1, 16'hFFFF, 0, 1'b0, 1'b1, 20'h00001, 1'b1, 1'b0, 5'b11110, lowCnt);
        applyStimulus(1, 16'h7FFF, 0, 1'b0, 1'b1, 20'h32767, 1'b0, 1'b0, 5'b00000, lowCnt);

        $display("[TB] overflow with four digits");
        applyStimulus(2, 16'd12345, 0, 1'b0, 1'b1, 20'h02345, 1'b0, 1'b1, 5'b00000, lowCnt);
        applyStimulus(2, 16'd9999, 0, 1'b0, 1'b1, 20'h09999, 1'b0, 1'b0, 5'b00000, lowCnt);

        $display("[TB] backpressure and ignored in_valid");
        applyStimulus(0, 16'd1234, 10, 1'b1, 1'b1, 20'h01234, 1'b0, 1'b0, 5'b10000, lowCnt);

        $display("[TB] reset mid-operation");
        cur = 0;
        inValid[0]  = 1'b1;
        binIn[0]    = 16'hFFFF;
        outReady[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", inReadyV[0], 1);
        checkOutput("midrst_out_valid", outValidV[0], 0);
        checkOutput("midrst_bcd", bcd0, 0);
        checkOutput("midrst_neg", negV[0], 0);
        checkOutput("midrst_ovf", ovfV[0], 0);
        checkOutput("midrst_blank", blank0, 5'b11110);
        @(negedge clk);
        #2 rst = 1'b0;
        outReady[0] = 1'b0;
        @(negedge clk);
        applyStimulus(0, 16'd100, 0, 1'b0, 1'b1, 20'h00100, 1'b0, 1'b0, 5'b11000, lowCnt);

        $display("[TB] randomized conversions");
        for (int i = 0; i < 40; i++) begin
            inst = $urandom_range(0, 2);
            sel  = $urandom_range(0, 7);
            case (sel)
                0:       v = 16'hFFFF;
                1:       v = 16'h0000;
                2:       v = 16'h8000;
                default: v = 16'($urandom);
            endcase
            applyStimulus(inst, v, $urandom_range(0, 3), 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 5'b0, lowCnt);
        end

        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
